// File: rtl/tmds_decode.sv
// Single-channel TMDS receive decoder: aligns the 10-bit word boundary with bitslip requests
// until a run of control tokens is seen, then decodes pixel bytes and c0/c1 control periods.
module tmds_decode #(
  parameter int unsigned CTRL_RUN       = 16,
  parameter int unsigned SEARCH_TIMEOUT = 4096,
  parameter int unsigned SLIP_WAIT      = 8,
  parameter int unsigned LOSS_TIMEOUT   = 65536
) (
  input  logic       clk1x,
  input  logic       rst,
  input  logic [9:0] din,
  output logic       bitslip,
  output logic       locked,
  output logic [7:0] dout,
  output logic       c0,
  output logic       c1,
  output logic       de
);

  localparam int unsigned RunW  = (CTRL_RUN > 1) ? $clog2(CTRL_RUN) : 1;
  localparam int unsigned TmoW  = (SEARCH_TIMEOUT > 1) ? $clog2(SEARCH_TIMEOUT) : 1;
  localparam int unsigned WaitW = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;
  localparam int unsigned LossW = (LOSS_TIMEOUT > 1) ? $clog2(LOSS_TIMEOUT) : 1;

  localparam logic [RunW-1:0]  RunLast  = RunW'(CTRL_RUN - 1);
  localparam logic [TmoW-1:0]  TmoLast  = TmoW'(SEARCH_TIMEOUT - 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(SLIP_WAIT - 1);
  localparam logic [LossW-1:0] LossLast = LossW'(LOSS_TIMEOUT - 1);

  localparam logic [9:0] TokC00 = 10'b1101010100;
  localparam logic [9:0] TokC01 = 10'b0010101011;
  localparam logic [9:0] TokC10 = 10'b0101010100;
  localparam logic [9:0] TokC11 = 10'b1010101011;

  typedef enum logic [1:0] {StSearch, StSlip, StWait, StLocked} state_e;

  state_e           state_q, state_d;
  logic [RunW-1:0]  run_q, run_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [LossW-1:0] loss_q, loss_d;

  logic [9:0] s1_word_q;
  logic       s1_tok_q;
  logic [1:0] s1_ctl_q;
  logic       tok_match;
  logic [1:0] tok_ctl;

  logic [1:0] ctl_last_q;
  logic [7:0] dout_q, dout_d;
  logic [1:0] ctl_q, ctl_d;
  logic       de_q, de_d;

  logic [7:0] dec_unmask;
  logic [7:0] dec_byte;
  logic       out_en;

  // Token match on the raw word
  always_comb begin
    tok_match = 1'b1;
    tok_ctl   = 2'b00;
    case (din)
      TokC00:  tok_ctl = 2'b00;
      TokC01:  tok_ctl = 2'b01;
      TokC10:  tok_ctl = 2'b10;
      TokC11:  tok_ctl = 2'b11;
      default: tok_match = 1'b0;
    endcase
  end

  // Stage 1: raw word plus token flag
  always_ff @(posedge clk1x) begin
    if (rst) begin
      s1_word_q <= '0;
      s1_tok_q  <= 1'b0;
      s1_ctl_q  <= 2'b00;
    end else begin
      s1_word_q <= din;
      s1_tok_q  <= tok_match;
      s1_ctl_q  <= tok_ctl;
    end
  end

  // Alignment FSM
  always_comb begin
    logic clr;
    clr     = 1'b0;
    state_d = state_q;
    run_d   = run_q;
    tmo_d   = tmo_q;
    wait_d  = wait_q;
    loss_d  = loss_q;
    unique case (state_q)
      StSearch: begin
        run_d = s1_tok_q ? run_q + 1'b1 : '0;
        tmo_d = tmo_q + 1'b1;
        if (s1_tok_q && (run_q == RunLast)) begin
          state_d = StLocked;
          clr     = 1'b1;
        end else if (tmo_q == TmoLast) begin
          state_d = StSlip;
          clr     = 1'b1;
        end
      end
      StSlip: begin
        state_d = StWait;
        clr     = 1'b1;
      end
      StWait: begin
        if (wait_q == WaitLast) begin
          state_d = StSearch;
          clr     = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StLocked: begin
        if (loss_q == LossLast) begin
          state_d = StSearch;
          clr     = 1'b1;
        end else begin
          loss_d = s1_tok_q ? '0 : loss_q + 1'b1;
        end
      end
      default: begin
        state_d = StSearch;
        clr     = 1'b1;
      end
    endcase
    if (clr) begin
      run_d  = '0;
      tmo_d  = '0;
      wait_d = '0;
      loss_d = '0;
    end
  end

  always_ff @(posedge clk1x) begin
    if (rst) begin
      state_q <= StSearch;
      run_q   <= '0;
      tmo_q   <= '0;
      wait_q  <= '0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      tmo_q   <= tmo_d;
      wait_q  <= wait_d;
      loss_q  <= loss_d;
    end
  end

  // Data decode: undo the optional inversion, then the XOR/XNOR chain
  always_comb begin
    dec_unmask  = s1_word_q[9] ? ~s1_word_q[7:0] : s1_word_q[7:0];
    dec_byte    = '0;
    dec_byte[0] = dec_unmask[0];
    for (int i = 1; i < 8; i++) begin
      dec_byte[i] = s1_word_q[8] ? (dec_unmask[i] ^ dec_unmask[i-1])
                                 : ~(dec_unmask[i] ^ dec_unmask[i-1]);
    end
  end

  // Outputs run only while locked both before and after this edge, so they zero on the same
  // edge that locked falls and start the cycle after locked rises.
  assign out_en = (state_q == StLocked) && (state_d == StLocked);

  always_comb begin
    dout_d = '0;
    ctl_d  = 2'b00;
    de_d   = 1'b0;
    if (out_en) begin
      if (s1_tok_q) begin
        ctl_d = s1_ctl_q;
      end else begin
        dout_d = dec_byte;
        ctl_d  = ctl_last_q;
        de_d   = 1'b1;
      end
    end
  end

  // Stage 2: decoded outputs
  always_ff @(posedge clk1x) begin
    if (rst) begin
      ctl_last_q <= 2'b00;
      dout_q     <= '0;
      ctl_q      <= 2'b00;
      de_q       <= 1'b0;
    end else begin
      if (s1_tok_q) begin
        ctl_last_q <= s1_ctl_q;
      end
      dout_q <= dout_d;
      ctl_q  <= ctl_d;
      de_q   <= de_d;
    end
  end

  assign bitslip = (state_q == StSlip);
  assign locked  = (state_q == StLocked);
  assign dout    = dout_q;
  assign c0      = ctl_q[0];
  assign c1      = ctl_q[1];
  assign de      = de_q;

endmodule

// File: tb/tb_tmds_decode.sv
// Directed bench for tmds_decode: lock timing, decode table, slip alignment, interrupted run,
// loss of lock and reset while locked.
module tb_tmds_decode;

  localparam int unsigned CR = 16;
  localparam int unsigned ST = 256;
  localparam int unsigned SW = 8;
  localparam int unsigned LT = 64;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;

  logic       clk1x = 1'b0;
  logic       rst   = 1'b1;
  logic [9:0] din   = '0;
  logic       bitslip, locked, c0, c1, de;
  logic [7:0] dout;

  int checks = 0;
  int errors = 0;

  // Bitslip monitor
  int slip_cnt  = 0;
  int wide_cnt  = 0;
  int close_cnt = 0;
  int cyc       = 0;
  int last_rise = -1;
  logic prev_slip = 1'b0;

  typedef struct {
    logic [9:0] w;
    logic       de;
    logic [7:0] dout;
    logic [1:0] cc;
  } vec_t;

  vec_t vecs[11];

  tmds_decode #(
    .CTRL_RUN      (CR),
    .SEARCH_TIMEOUT(ST),
    .SLIP_WAIT     (SW),
    .LOSS_TIMEOUT  (LT)
  ) dut (
    .clk1x  (clk1x),
    .rst    (rst),
    .din    (din),
    .bitslip(bitslip),
    .locked (locked),
    .dout   (dout),
    .c0     (c0),
    .c1     (c1),
    .de     (de)
  );

  always #5 clk1x = ~clk1x;

  always @(negedge clk1x) begin
    cyc = cyc + 1;
    if (bitslip) begin
      slip_cnt = slip_cnt + 1;
      if (prev_slip) begin
        wide_cnt = wide_cnt + 1;
      end else begin
        if (last_rise >= 0 && (cyc - last_rise) < int'(ST + SW)) close_cnt = close_cnt + 1;
        last_rise = cyc;
      end
    end
    prev_slip = bitslip;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1x);
    #1;
  endtask

  task automatic drive(input logic [9:0] w);
    din = w;
    tick();
  endtask

  task automatic do_reset(input logic [9:0] w);
    rst = 1'b1;
    din = w;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [9:0] rot(input logic [9:0] t, input int off);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = t[(i + off) % 10];
    return r;
  endfunction

  initial begin
    int s0;
    int off;
    // Encoder words (running disparity from 0): 00, FF, A5, 10, 00 (inverted form)
    vecs[0]  = '{T11,    1'b0, 8'h00, 2'b11};
    vecs[1]  = '{10'h100, 1'b1, 8'h00, 2'b11};
    vecs[2]  = '{10'h0FF, 1'b1, 8'hFF, 2'b11};
    vecs[3]  = '{10'h163, 1'b1, 8'hA5, 2'b11};
    vecs[4]  = '{10'h1F0, 1'b1, 8'h10, 2'b11};
    vecs[5]  = '{10'h3FF, 1'b1, 8'h00, 2'b11};
    vecs[6]  = '{T01,    1'b0, 8'h00, 2'b01};
    vecs[7]  = '{10'h20F, 1'b1, 8'hEE, 2'b01};
    vecs[8]  = '{T10,    1'b0, 8'h00, 2'b10};
    vecs[9]  = '{T00,    1'b0, 8'h00, 2'b00};
    vecs[10] = '{10'h163, 1'b1, 8'hA5, 2'b00};

    // Reset with a token stream already present
    rst = 1'b1;
    din = T00;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("reset_outputs", {bitslip, locked, dout, c1, c0, de}, '0);
    end
    rst = 1'b0;
    s0 = slip_cnt;
    for (int k = 1; k <= int'(CR) + 1; k++) begin
      drive(T00);
      check("lock_rise", locked, (k == int'(CR) + 1));
    end
    check("lock_ctl_de", {c1, c0, de}, 3'b000);

    // Decode table, two cycles of latency
    for (int i = 0; i <= 11; i++) begin
      drive((i < 11) ? vecs[i].w : T00);
      if (i > 0) begin
        check("dec_de", de, vecs[i-1].de);
        check("dec_dout", dout, vecs[i-1].dout);
        check("dec_ctl", {c1, c0}, vecs[i-1].cc);
      end
    end
    check("no_slip_locked", slip_cnt - s0, 0);

    // Loss of lock after LT data words
    for (int k = 1; k <= int'(LT); k++) begin
      drive(10'h100);
      if (k == int'(LT)) begin
        check("loss_still_locked", locked, 1'b1);
        check("loss_still_de", de, 1'b1);
      end
    end
    drive(T00);
    check("loss_locked", locked, 1'b0);
    check("loss_outputs", {dout, c1, c0, de}, '0);
    check("loss_no_slip", bitslip, 1'b0);
    drive(T00);
    check("loss_no_slip2", bitslip, 1'b0);

    // Relock, stream data, then a one-cycle reset
    for (int k = 0; k < 40 && !locked; k++) drive(T00);
    check("relock", locked, 1'b1);
    drive(10'h163);
    drive(10'h163);
    drive(10'h163);
    check("stream_dout", {de, dout}, {1'b1, 8'hA5});
    rst = 1'b1;
    din = T00;
    tick();
    check("midlock_reset", {bitslip, locked, dout, c1, c0, de}, '0);
    rst = 1'b0;
    for (int k = 1; k <= int'(CR) + 1; k++) begin
      drive(T00);
      check("midlock_relock", locked, (k == int'(CR) + 1));
    end

    // Interrupted run: CR-1 tokens, one data word, then CR tokens
    do_reset(10'h100);
    s0 = slip_cnt;
    for (int k = 1; k <= 2 * int'(CR) + 1; k++) begin
      drive((k == int'(CR)) ? 10'h0FF : T11);
      check("interrupt_lock", locked, (k == 2 * int'(CR) + 1));
    end
    check("interrupt_no_slip", slip_cnt - s0, 0);

    // Misaligned stream: deserializer model shifts its boundary on each bitslip
    do_reset(10'h100);
    s0  = slip_cnt;
    wide_cnt  = 0;
    close_cnt = 0;
    last_rise = -1;
    off = 7;
    for (int k = 0; k < 3000 && !locked; k++) begin
      drive(rot(T10, off));
      if (bitslip) off = (off + 1) % 10;
    end
    check("align_locked", locked, 1'b1);
    check("align_slips", slip_cnt - s0, 3);
    check("align_wide", wide_cnt, 0);
    check("align_spacing", close_cnt, 0);
    drive(rot(T10, off));
    check("align_ctl", {c1, c0, de}, 3'b100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
